dmem_mmio: RTL and testbench

Memory-side responder for the processor's M-stage data port: it accepts the address, write data and write strobe, and returns load data in the same cycle. It holds a word-addressed data RAM and a small MMIO page. The page provides an LED register, synchronized switch inputs, a 64-bit cycle counter, a one-shot down-timer with interrupt flag, and a byte TX FIFO drained over a valid/ready port toward a console or UART.

---
 rtl/dmem_mmio.sv | 171 +++++++++++++++++
 tb/tb_dmem_mmio.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory responder for the M-stage data port.
// Word-addressed RAM with asynchronous read, plus a 32-byte MMIO page holding
// LED, synchronized switches, a 64-bit cycle counter, a one-shot down-timer
// with sticky flag, and a byte TX FIFO drained over valid/ready.
module dmem_mmio #(
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          TX_DEPTH   = 8,
  parameter int          LED_W      = 10,
  parameter int          SW_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemWriteM,
  input  logic [31:0]      ALUResultM,
  input  logic [31:0]      WriteDataM,
  output logic [31:0]      ReadDataM,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             timer_irq
);

  localparam int RamAw = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int PtrW  = $clog2(TX_DEPTH);
  localparam int CntW  = PtrW + 1;

  localparam logic [2:0] IdxLed    = 3'd0;
  localparam logic [2:0] IdxSw     = 3'd1;
  localparam logic [2:0] IdxCycLo  = 3'd2;
  localparam logic [2:0] IdxCycHi  = 3'd3;
  localparam logic [2:0] IdxTimer  = 3'd4;
  localparam logic [2:0] IdxTxData = 3'd5;
  localparam logic [2:0] IdxStatus = 3'd6;

  // ---------------------------------------------------------------- decode
  logic             ramHit;
  logic             mmioHit;
  logic [2:0]       regIdx;
  logic [RamAw-1:0] ramIdx;
  logic             unusedAddrBits;

  assign ramHit         = ({2'b00, ALUResultM[31:2]} < 32'(DMEM_WORDS));
  assign mmioHit        = (ALUResultM[31:5] == MMIO_BASE[31:5]);
  assign regIdx         = ALUResultM[4:2];
  assign ramIdx         = ALUResultM[RamAw+1:2];
  assign unusedAddrBits = ^ALUResultM[1:0];

  logic wrRam, wrLed, wrCycLo, wrTimer, wrTx, wrStatus;
  assign wrRam    = MemWriteM && ramHit;
  assign wrLed    = MemWriteM && mmioHit && (regIdx == IdxLed);
  assign wrCycLo  = MemWriteM && mmioHit && (regIdx == IdxCycLo);
  assign wrTimer  = MemWriteM && mmioHit && (regIdx == IdxTimer);
  assign wrTx     = MemWriteM && mmioHit && (regIdx == IdxTxData);
  assign wrStatus = MemWriteM && mmioHit && (regIdx == IdxStatus);

  // ---------------------------------------------------------------- state
  logic [31:0]      ram [DMEM_WORDS];
  logic [7:0]       txMem [TX_DEPTH];
  logic [LED_W-1:0] ledReg;
  logic [SW_W-1:0]  swMetaReg, swSyncReg;
  logic [63:0]      cycleReg;
  logic [31:0]      timerReg, timerNext;
  logic             timerFlagReg, timerFlagNext, timerSet;
  logic [PtrW-1:0]  rdPtrReg, wrPtrReg;
  logic [CntW-1:0]  txCountReg, txCountNext;
  logic             txOverflowReg, txOverflowNext;

  // FIFO status and handshake terms, all taken from pre-edge state
  logic txFull, txEmpty, txPop, txAccept, txDrop;
  assign txFull   = (txCountReg == CntW'(TX_DEPTH));
  assign txEmpty  = (txCountReg == '0);
  assign txPop    = !txEmpty && tx_ready;
  assign txAccept = wrTx && (!txFull || txPop);
  assign txDrop   = wrTx && txFull && !txPop;

  // RAM write port; contents are deliberately left alone by reset
  always_ff @(posedge clk) begin
    if (wrRam) ram[ramIdx] <= WriteDataM;
  end

  // FIFO storage; the head is masked to 0 when empty so it needs no reset
  always_ff @(posedge clk) begin
    if (txAccept) txMem[wrPtrReg] <= WriteDataM[7:0];
  end

  // Timer next value, terminal-step flag set, and sticky-bit updates (set beats W1C)
  always_comb begin
    timerNext = timerReg;
    timerSet  = 1'b0;
    if (wrTimer) begin
      timerNext = WriteDataM;
    end else if (timerReg != 32'd0) begin
      timerNext = timerReg - 32'd1;
      timerSet  = (timerReg == 32'd1);
    end
    timerFlagNext  = (timerFlagReg & ~(wrStatus & WriteDataM[17])) | timerSet;
    txOverflowNext = (txOverflowReg & ~(wrStatus & WriteDataM[16])) | txDrop;
  end

  // FIFO occupancy: accepted push and pop in the same cycle cancel out
  always_comb begin
    txCountNext = txCountReg;
    if (txAccept && !txPop)      txCountNext = txCountReg + CntW'(1);
    else if (!txAccept && txPop) txCountNext = txCountReg - CntW'(1);
  end

  // Registered MMIO state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ledReg        <= '0;
      swMetaReg     <= '0;
      swSyncReg     <= '0;
      cycleReg      <= '0;
      timerReg      <= '0;
      timerFlagReg  <= 1'b0;
      rdPtrReg      <= '0;
      wrPtrReg      <= '0;
      txCountReg    <= '0;
      txOverflowReg <= 1'b0;
    end else begin
      if (wrLed) ledReg <= WriteDataM[LED_W-1:0];
      swMetaReg     <= sw;
      swSyncReg     <= swMetaReg;
      cycleReg      <= wrCycLo ? 64'd0 : cycleReg + 64'd1;
      timerReg      <= timerNext;
      timerFlagReg  <= timerFlagNext;
      if (txPop)    rdPtrReg <= rdPtrReg + PtrW'(1);
      if (txAccept) wrPtrReg <= wrPtrReg + PtrW'(1);
      txCountReg    <= txCountNext;
      txOverflowReg <= txOverflowNext;
    end
  end

  // STATUS word assembled from current FIFO and sticky state
  logic [31:0] statusWord;
  always_comb begin
    statusWord      = '0;
    statusWord[0]   = txFull;
    statusWord[1]   = txEmpty;
    statusWord[8:4] = 5'(txCountReg);
    statusWord[16]  = txOverflowReg;
    statusWord[17]  = timerFlagReg;
  end

  // Load data mux: RAM, MMIO page, or 0 for unmapped/write-only/reserved
  always_comb begin
    ReadDataM = '0;
    if (ramHit) begin
      ReadDataM = ram[ramIdx];
    end else if (mmioHit) begin
      case (regIdx)
        IdxLed:    ReadDataM = 32'(ledReg);
        IdxSw:     ReadDataM = 32'(swSyncReg);
        IdxCycLo:  ReadDataM = cycleReg[31:0];
        IdxCycHi:  ReadDataM = cycleReg[63:32];
        IdxTimer:  ReadDataM = timerReg;
        IdxStatus: ReadDataM = statusWord;
        default:   ReadDataM = '0;
      endcase
    end
  end

  assign led       = ledReg;
  assign tx_valid  = !txEmpty;
  assign tx_data   = txEmpty ? 8'h00 : txMem[rdPtrReg];
  assign timer_irq = timerFlagReg;

endmodule

// File: tb/tb_dmem_mmio.sv
// Testbench for dmem_mmio: table of RAM/MMIO vectors plus hand-written
// sequences for cycle counter, timer, TX FIFO and asynchronous reset.
// Read expectations and FIFO bytes go through scoreboard queues.
module tb_dmem_mmio;

  localparam logic [31:0] LED_A = 32'h1000_0000;
  localparam logic [31:0] SW_A  = 32'h1000_0004;
  localparam logic [31:0] CLO_A = 32'h1000_0008;
  localparam logic [31:0] CHI_A = 32'h1000_000C;
  localparam logic [31:0] TMR_A = 32'h1000_0010;
  localparam logic [31:0] TXD_A = 32'h1000_0014;
  localparam logic [31:0] STS_A = 32'h1000_0018;
  localparam logic [31:0] RSV_A = 32'h1000_001C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic [9:0]  sw = '0;
  logic [9:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        timer_irq;

  dmem_mmio dut (
    .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .sw(sw), .led(led),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rdExp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  int         nVec = 0;
  int         nErr = 0;
  rdExp_t     rdQ[$];
  logic [7:0] txQ[$];
  logic       ovfModel = 1'b0;
  vec_t       vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] statusExp(input logic flag);
    logic [31:0] s;
    s       = '0;
    s[0]    = (txQ.size() == 8);
    s[1]    = (txQ.size() == 0);
    s[8:4]  = 5'(txQ.size());
    s[16]   = ovfModel;
    s[17]   = flag;
    return s;
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic chk, input logic [31:0] exp, input string name);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.chk = chk; v.exp = exp; v.name = name;
    return v;
  endfunction

  // One bus cycle: drive after an edge, sample at the falling edge, then
  // advance the FIFO model as the coming rising edge will.
  task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic rdy, input logic chk, input logic [31:0] exp,
                      input string name);
    rdExp_t e;
    logic   pop;
    logic   full;
    MemWriteM  = we;
    ALUResultM = addr;
    WriteDataM = wd;
    tx_ready   = rdy;
    if (chk) begin
      e.name = name;
      e.exp  = exp;
      rdQ.push_back(e);
    end
    @(negedge clk);
    $display("txn %-24s we=%0b addr=%08h wd=%08h rd=%08h txv=%0b txd=%02h rdy=%0b irq=%0b",
             name, we, addr, wd, ReadDataM, tx_valid, tx_data, rdy, timer_irq);
    if (chk) begin
      e = rdQ.pop_front();
      check(e.name, ReadDataM, e.exp);
    end
    check("tx_valid", {31'b0, tx_valid}, {31'b0, txQ.size() != 0});
    check("tx_data", {24'b0, tx_data}, {24'b0, (txQ.size() != 0) ? txQ[0] : 8'h00});
    full = (txQ.size() == 8);
    pop  = (txQ.size() != 0) && rdy;
    if (pop) txQ.delete(0);
    if (we && addr == TXD_A) begin
      if (!full || pop) txQ.push_back(wd[7:0]);
      else ovfModel = 1'b1;
    end else if (we && addr == STS_A && wd[16]) begin
      ovfModel = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "idle");
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    ALUResultM = CLO_A;
    #1;
    check("rst led", {22'b0, led}, 32'h0);
    check("rst tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst tx_data", {24'b0, tx_data}, 32'h0);
    check("rst timer_irq", {31'b0, timer_irq}, 32'h0);
    check("rst cycle_lo", ReadDataM, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // cycle counter from reset release: region after the Nth edge reads N
    idle(99);
    step(1'b0, CLO_A, 0, 1'b0, 1'b1, 32'd100, "cycle_lo after 100");
    step(1'b0, CHI_A, 0, 1'b0, 1'b1, 32'd0, "cycle_hi");

    // switch synchronizer: new value visible 2 edges after the change
    sw = 10'h155;
    step(1'b0, SW_A, 0, 1'b0, 1'b1, 32'h0, "sw +0 edges");
    step(1'b0, SW_A, 0, 1'b0, 1'b1, 32'h0, "sw +1 edge");
    step(1'b0, SW_A, 0, 1'b0, 1'b1, 32'h155, "sw +2 edges");

    // table-driven RAM / simple MMIO vectors
    vt.push_back(mk(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, "st 0x10"));
    vt.push_back(mk(1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, "ld 0x10 next cycle"));
    vt.push_back(mk(1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h0, "ld past ram top"));
    vt.push_back(mk(1'b0, 32'h2000_0000, 32'h0, 1'b1, 32'h0, "ld unmapped"));
    vt.push_back(mk(1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0, 32'h0, "st 0x0"));
    vt.push_back(mk(1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 1'b0, 32'h0, "st unmapped"));
    vt.push_back(mk(1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'hA5A5_A5A5, "ld 0x0 no alias"));
    vt.push_back(mk(1'b1, 32'h0000_0FFC, 32'h1234_5678, 1'b0, 32'h0, "st top word"));
    vt.push_back(mk(1'b0, 32'h0000_0FFE, 32'h0, 1'b1, 32'h1234_5678, "ld top word low bits"));
    vt.push_back(mk(1'b1, LED_A, 32'hFFFF_FFFF, 1'b0, 32'h0, "st led all ones"));
    vt.push_back(mk(1'b0, LED_A, 32'h0, 1'b1, 32'h0000_03FF, "ld led masked"));
    vt.push_back(mk(1'b1, RSV_A, 32'hFFFF_FFFF, 1'b0, 32'h0, "st reserved"));
    vt.push_back(mk(1'b0, RSV_A, 32'h0, 1'b1, 32'h0, "ld reserved"));
    vt.push_back(mk(1'b0, TXD_A, 32'h0, 1'b1, 32'h0, "ld tx_data reg"));
    vt.push_back(mk(1'b0, STS_A, 32'h0, 1'b1, 32'h0000_0002, "ld status idle"));
    vt.push_back(mk(1'b0, TMR_A, 32'h0, 1'b1, 32'h0, "ld timer idle"));
    vt.push_back(mk(1'b1, LED_A, 32'h0000_02A5, 1'b0, 32'h0, "st led 2a5"));
    vt.push_back(mk(1'b0, LED_A, 32'h0, 1'b1, 32'h0000_02A5, "ld led 2a5"));
    vt.push_back(mk(1'b0, 32'h1000_0020, 32'h0, 1'b1, 32'h0, "ld past mmio page"));
    for (int i = 0; i < vt.size(); i++)
      step(vt[i].we, vt[i].addr, vt[i].wd, 1'b0, vt[i].chk, vt[i].exp, vt[i].name);
    check("led port", {22'b0, led}, 32'h0000_02A5);

    // cycle clear: 0 after the write edge, then counts up again
    step(1'b1, CLO_A, 32'h1234, 1'b0, 1'b0, 32'h0, "clear cycle");
    step(1'b0, CLO_A, 0, 1'b0, 1'b1, 32'd0, "cycle after clear");
    step(1'b0, CLO_A, 0, 1'b0, 1'b1, 32'd1, "cycle +1");
    idle(98);
    step(1'b0, CLO_A, 0, 1'b0, 1'b1, 32'd100, "cycle +100");

    // timer: load 5, flag exactly 5 edges after the load edge
    step(1'b1, TMR_A, 32'd5, 1'b0, 1'b0, 32'h0, "load timer 5");
    for (int j = 1; j <= 5; j++) begin
      check("irq before terminal", {31'b0, timer_irq}, 32'h0);
      step(1'b0, TMR_A, 0, 1'b0, 1'b1, 32'(6 - j), "timer countdown");
    end
    check("irq at terminal", {31'b0, timer_irq}, 32'h1);
    step(1'b0, STS_A, 0, 1'b0, 1'b1, statusExp(1'b1), "status flag set");
    step(1'b0, TMR_A, 0, 1'b0, 1'b1, 32'h0, "timer holds 0");
    step(1'b1, STS_A, 32'h0002_0000, 1'b0, 1'b1, statusExp(1'b1), "w1c flag");
    check("irq after w1c", {31'b0, timer_irq}, 32'h0);
    step(1'b0, STS_A, 0, 1'b0, 1'b1, statusExp(1'b0), "status flag clear");

    // loading 0 never sets the flag
    step(1'b1, TMR_A, 32'd0, 1'b0, 1'b0, 32'h0, "load timer 0");
    idle(3);
    check("irq after load 0", {31'b0, timer_irq}, 32'h0);

    // rewrite on the terminal cycle wins over the 1->0 step
    step(1'b1, TMR_A, 32'd2, 1'b0, 1'b0, 32'h0, "load timer 2");
    step(1'b0, TMR_A, 0, 1'b0, 1'b1, 32'd2, "timer 2");
    step(1'b1, TMR_A, 32'd0, 1'b0, 1'b1, 32'd1, "rewrite at terminal");
    check("irq after rewrite", {31'b0, timer_irq}, 32'h0);
    step(1'b0, STS_A, 0, 1'b0, 1'b1, statusExp(1'b0), "status no flag");

    // hardware set beats a same-cycle W1C
    step(1'b1, TMR_A, 32'd1, 1'b0, 1'b0, 32'h0, "load timer 1");
    step(1'b1, STS_A, 32'h0002_0000, 1'b0, 1'b1, statusExp(1'b0), "w1c with set");
    check("set beats w1c", {31'b0, timer_irq}, 32'h1);
    step(1'b1, STS_A, 32'h0002_0000, 1'b0, 1'b0, 32'h0, "w1c flag");
    check("irq cleared", {31'b0, timer_irq}, 32'h0);

    // TX FIFO fill with consumer stalled
    for (int i = 0; i < 8; i++)
      step(1'b1, TXD_A, 32'(8'h41 + i), 1'b0, 1'b0, 32'h0, "push");
    step(1'b0, STS_A, 0, 1'b0, 1'b1, statusExp(1'b0), "status full");
    check("status full literal", statusExp(1'b0), 32'h0000_0081);
    step(1'b1, TXD_A, 32'h49, 1'b0, 1'b0, 32'h0, "push when full");
    step(1'b0, STS_A, 0, 1'b0, 1'b1, statusExp(1'b0), "status overflow");
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, "drain");
    step(1'b0, STS_A, 0, 1'b1, 1'b1, statusExp(1'b0), "status drained");
    step(1'b1, STS_A, 32'h0001_0000, 1'b0, 1'b0, 32'h0, "w1c overflow");
    step(1'b0, STS_A, 0, 1'b0, 1'b1, statusExp(1'b0), "status ovf clear");

    // full FIFO: push with simultaneous pop is accepted, no overflow
    for (int i = 0; i < 8; i++)
      step(1'b1, TXD_A, 32'(8'h51 + i), 1'b0, 1'b0, 32'h0, "push");
    step(1'b1, TXD_A, 32'h59, 1'b1, 1'b0, 32'h0, "push+pop when full");
    step(1'b0, STS_A, 0, 1'b0, 1'b1, statusExp(1'b0), "status still full");
    for (int i = 0; i < 9; i++) step(1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, "drain wrap");

    // async reset mid-drain and mid-countdown
    step(1'b1, TMR_A, 32'd1, 1'b0, 1'b0, 32'h0, "load timer 1");
    step(1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0, "idle");
    step(1'b1, TMR_A, 32'd50, 1'b0, 1'b0, 32'h0, "load timer 50");
    for (int i = 0; i < 3; i++)
      step(1'b1, TXD_A, 32'(8'h61 + i), 1'b0, 1'b0, 32'h0, "push");
    step(1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0, "drain one");
    check("irq before reset", {31'b0, timer_irq}, 32'h1);
    MemWriteM = 1'b0;
    tx_ready  = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async rst led", {22'b0, led}, 32'h0);
    check("async rst tx_valid", {31'b0, tx_valid}, 32'h0);
    check("async rst tx_data", {24'b0, tx_data}, 32'h0);
    check("async rst timer_irq", {31'b0, timer_irq}, 32'h0);
    ALUResultM = STS_A;
    #1;
    check("async rst status", ReadDataM, 32'h0000_0002);
    ALUResultM = TMR_A;
    #1;
    check("async rst timer", ReadDataM, 32'h0);
    ALUResultM = CLO_A;
    #1;
    check("async rst cycle", ReadDataM, 32'h0);
    ALUResultM = SW_A;
    #1;
    check("async rst sw sync", ReadDataM, 32'h0);
    txQ.delete();
    ovfModel = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 32'h0000_0010, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, "ram kept over reset");
    step(1'b0, STS_A, 0, 1'b0, 1'b1, statusExp(1'b0), "status after reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
